cla_multiword_sequencer: RTL and testbench

- Multi-precision add controller: adds two W-bit operands by iterating one N-bit carry-look-ahead slice over K=W/N beats, least-significant slice first.
- The carry is registered between beats.
- Sits between a requester (valid/ready source) and a consumer (valid/ready sink); trades latency for a narrow adder datapath.

---
 rtl/cla_multiword_sequencer_pkg.sv | 19 +
 rtl/cla_slice.sv | 41 ++++
 rtl/cla_multiword_sequencer.sv | 124 ++++++++++++
 tb/tb_cla_multiword_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_multiword_sequencer_pkg.sv
// Shared types and helpers for the multi-word carry-look-ahead add sequencer.
package cla_multiword_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_N = 4;
  localparam int unsigned DEF_W = 16;
  localparam int unsigned DEF_K = DEF_W / DEF_N;

  // Beat counter width: wide enough for 0..K-1, never narrower than one bit.
  function automatic int unsigned beat_cnt_w(input int unsigned k);
    return (k <= 1) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational N-bit generate/propagate carry-look-ahead adder slice.
module cla_slice #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N-1:0] w_g;
  logic [N-1:0] w_p;
  logic [N:0]   w_c;
  logic         w_t;
  logic         w_pp;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is a flat sum-of-products of generate/propagate terms and cin.
  always_comb begin
    w_c    = '0;
    w_t    = 1'b0;
    w_pp   = 1'b0;
    w_c[0] = cin;
    for (int unsigned i = 0; i < N; i++) begin
      w_t  = w_g[i];
      w_pp = w_p[i];
      for (int unsigned j = 0; j < i; j++) begin
        w_t  = w_t | (w_pp & w_g[i-1-j]);
        w_pp = w_pp & w_p[i-1-j];
      end
      w_c[i+1] = w_t | (w_pp & cin);
    end
  end

  assign s    = w_p ^ w_c[N-1:0];
  assign cout = w_c[N];

endmodule

// File: rtl/cla_multiword_sequencer.sv
// Multi-precision adder: iterates one N-bit CLA slice over K=W/N beats, LSB slice first.
module cla_multiword_sequencer
  import cla_multiword_sequencer_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Sum,
  output logic         Cout,
  output logic         Ovf,
  output logic         busy
);

  localparam int unsigned K  = W / N;
  localparam int unsigned BW = beat_cnt_w(K);

  // Reject slice/operand widths that do not tile evenly.
  generate
    if (N < 1 || (W % N) != 0 || K < 1) begin : g_param_err
      $error("cla_multiword_sequencer: W must be a positive multiple of N");
    end
  endgenerate

  state_e        r_state;
  logic [BW-1:0] r_beat;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          r_ovf;
  logic          r_out_valid;
  logic          r_busy;

  logic [N-1:0]  w_a_sl;
  logic [N-1:0]  w_b_sl;
  logic [N-1:0]  w_s;
  logic          w_cout;
  logic          w_last;

  // Select the current beat's slice of the latched operands.
  assign w_a_sl = N'(r_a >> (N * 32'(r_beat)));
  assign w_b_sl = N'(r_b >> (N * 32'(r_beat)));
  assign w_last = (r_beat == BW'(K - 1));

  cla_slice #(.N(N)) u_slice (
    .a    (w_a_sl),
    .b    (w_b_sl),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // Sequencer FSM: accept in IDLE, one slice per edge in RUN, hold result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
            r_beat  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum[N*32'(r_beat) +: N] <= w_s;
          r_carry                   <= w_cout;
          if (w_last) begin
            r_beat      <= '0;
            r_cout      <= w_cout;
            r_ovf       <= (r_a[W-1] == r_b[W-1]) && (w_s[N-1] != r_a[W-1]);
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_DONE;
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign Ovf       = r_ovf;

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Scoreboard bench for cla_multiword_sequencer (N=4, W=16).
module tb_cla_multiword_sequencer;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;
  localparam int unsigned K = W / N;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] tb_a;
  logic [W-1:0] tb_b;
  logic         tb_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  exp_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   n_done   = 0;
  int   n_issued = 0;
  bit   mon_en   = 1'b0;
  bit   rnd_rdy  = 1'b0;
  logic prev_valid = 1'b0;

  cla_multiword_sequencer #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (tb_a),
    .B         (tb_b),
    .Cin       (tb_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (sum),
    .Cout      (cout),
    .Ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: whole-word arithmetic, no slicing.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    e.acc_cyc = 0;
    return e;
  endfunction

  // Monitor: pops the scoreboard on each output handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy || out_valid) chk("in_ready_low", 32'(in_ready), 32'd0);
      if (out_valid && !prev_valid) begin
        if (q.size() != 0) chk("latency", 32'(cyc - q[0].acc_cyc), 32'(K));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h required=none", sum);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum",  32'(sum),  32'(e.sum));
          chk("cout", 32'(cout), 32'(e.cout));
          chk("ovf",  32'(ovf),  32'(e.ovf));
          n_done++;
        end
      end
      prev_valid = out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Random backpressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present an op, wait for acceptance in IDLE, push its expected result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input bit keep, output int acc);
    exp_t e;
    bit   ok;
    tb_a = a; tb_b = b; tb_cin = c; in_valid = 1'b1;
    ok = 1'b0;
    acc = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      e = model(a, b, c);
      e.acc_cyc = cyc + 1;
      acc = cyc + 1;
      q.push_back(e);
      n_issued++;
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      if (q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", 32'(q.size()), 32'd0);
    #1;
  endtask

  initial begin
    int   acc;
    int   set_cyc;
    bit   ok;
    rst_n = 1'b0; in_valid = 1'b0; tb_a = '0; tb_b = '0; tb_cin = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_sum",       32'(sum),       32'd0);
    chk("rst_cout",      32'(cout),      32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; mon_en = 1'b1;

    // Directed arithmetic cases.
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, acc);
    @(negedge clk);
    chk("busy_in_run", 32'(busy), 32'd1);
    drain();
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc); drain();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, acc); drain();
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, acc); drain();

    // Backpressure: result must hold while new operands are offered.
    out_ready = 1'b0;
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, acc);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("bp_valid_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    tb_a = 16'hAAAA; tb_b = 16'h5555; tb_cin = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_sum",       32'(sum),       32'h3333);
      chk("bp_cout",      32'(cout),      32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
    end
    @(posedge clk); #1;
    set_cyc = cyc;
    out_ready = 1'b1;
    issue(16'hAAAA, 16'h5555, 1'b1, 1'b0, acc);
    chk("bp_accept_gap", 32'(acc - set_cyc >= 2), 32'd1);
    drain();

    // Reset in the middle of RUN discards the op.
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, acc);
    @(posedge clk); @(posedge clk); #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy",      32'(busy),      32'd0);
    chk("midrst_sum",       32'(sum),       32'd0);
    chk("midrst_cout",      32'(cout),      32'd0);
    chk("midrst_ovf",       32'(ovf),       32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    q.delete();
    n_issued--;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; mon_en = 1'b1;
    issue(16'h0000, 16'h0000, 1'b1, 1'b0, acc); drain();

    // Back-to-back with in_valid held high.
    issue(16'h0001, 16'h0002, 1'b0, 1'b1, acc);
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, acc);
    issue(16'h000F, 16'h0000, 1'b1, 1'b0, acc);
    drain();
    repeat (10) @(posedge clk);
    #1;

    // Randomized ops with random backpressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
    end
    in_valid = 1'b0;
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (10) @(posedge clk);
    #1;
    chk("op_count", 32'(n_done), 32'(n_issued));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
